frm_source: RTL and testbench
=============================

// Module: frm_source
// PURPOSE
//   Video stream generator driving the frame-statistics path (vs/de/wd) from the producing side.
//   Emits the raster timing (hs, vs, de) and an 8-bit pixel word per active pixel.
//   Pixel content is selected per frame from a level and a pattern mode.
//   Used as the on-chip test source and as the bench driver for the per-frame brightness decision logic.
// PARAMETERS
//   H_ACTIVE  16  active pixels per line
//   H_FP      2   horizontal front porch (cycles)
//   H_SYNC    4   hsync width (cycles)
//   H_BP      2   horizontal back porch (cycles); H_TOTAL = sum = 24
//   V_ACTIVE  8   active lines per frame
//   V_FP      1   vertical front porch (lines)
//   V_SYNC    2   vsync width (lines)
//   V_BP      1   vertical back porch (lines); V_TOTAL = sum = 12
// PORTS
//   clk_i       in   1  pixel clock
//   rst_i       in   1  synchronous reset, active-high
//   en_i        in   1  run request
//   mode_i      in   2  pattern: 0 solid, 1 h-gradient, 2 checker, 3 solid inverted
//   level_i     in   8  base pixel level
//   hs_o        out  1  hsync, active-high
//   vs_o        out  1  vsync, active-high
//   de_o        out  1  data enable
//   wd_o        out  8  pixel word
//   frm_done_o  out  1  one-cycle pulse at last cycle of each frame
//   frm_cnt_o   out  8  completed-frame count, wraps 255->0
// BEHAVIOUR
//   - Reset: FSM=IDLE, h_cnt=v_cnt=0, all outputs 0, latched level/mode 0. Reset mid-frame aborts: outputs 0 next cycle.
//   - FSM IDLE: counters held at 0, outputs 0. en_i=1 sampled -> RUN; counters start at (0,0) next cycle.
//   - FSM RUN: h_cnt 0..H_TOTAL-1, wraps; v_cnt increments on h wrap, range 0..V_TOTAL-1.
//   - Line order: active, FP, sync, BP. Frame order: active lines, FP, sync, BP.
//   - Counter (h,v) decode, all outputs registered (1 cycle after counter state):
//     de = h<H_ACTIVE && v<V_ACTIVE
//     hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, every line incl. blanking
//     vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, whole lines
//   - en_i=1 sampled in IDLE at cycle t -> first de_o=1 at t+2.
//   - Level/mode latch: level_i and mode_i captured when counter is at (0,0), i.e. IDLE->RUN and every frame wrap.
//     Mid-frame changes are ignored until the next frame.
//   - wd_o when de: mode0 = L; mode1 = L + h[7:0] (mod 256); mode2 = (h[2]^v[2]) ? ~L : L; mode3 = ~L.
//     wd_o = 0 whenever de_o = 0.
//   - Frame end: counter at (H_TOTAL-1, V_TOTAL-1). frm_done_o pulses (aligned with registered outputs), frm_cnt_o+1.
//     en_i=1 -> wrap to (0,0); en_i=0 -> IDLE. Frames always complete; en_i drop mid-frame has no effect until frame end.
//   - Simultaneous rst_i and frame end: reset wins; no pulse, count stays 0.
//   - Counter widths: $clog2(H_TOTAL), $clog2(V_TOTAL); no other arithmetic overflow.
// TESTING
//   1. rst_i held 3 cycles -> all outputs 0, frm_cnt_o=0; en_i=0 for 100 cycles -> outputs stay 0.
//   2. en=1, mode0, level 0x40 -> per frame 128 de cycles (8 lines x 16), all wd=0x40; hs 4 cycles/line;
//      vs 48 contiguous cycles; frame 288 cycles.
//   3. level_i 0x40->0xC0 at mid-frame line 3 -> rest of frame 0x40, next frame all 0xC0.
//   4. mode1, level 0xF8 -> line pixels F8,F9..FF,00..07; mode2, level 0x10 -> 64 pixels 0x10, 64 pixels 0xEF per frame.
//   5. en_i dropped at line 4 -> frame finishes, frm_done_o one pulse, frm_cnt_o=1, then IDLE outputs 0.
//   6. rst_i asserted mid-active line -> next cycle all outputs 0; en=1 restarts with first de at t+2.

Source files
------------

// File: rtl/frm_source.sv
// Raster video source: hs/vs/de timing plus an 8-bit pixel word chosen per frame
// from a latched level and pattern mode.
module frm_source #(
    parameter int H_ACTIVE = 16,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 8,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] level_i,
    output logic       hs_o,
    output logic       vs_o,
    output logic       de_o,
    output logic [7:0] wd_o,
    output logic       frm_done_o,
    output logic [7:0] frm_cnt_o,
    output logic       state_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [7:0]    lvl_q;
    logic [1:0]    mode_q;

    logic          h_last;
    logic          frame_end;
    logic          load;
    logic          hs_d;
    logic          vs_d;
    logic          de_d;
    logic [7:0]    wd_d;

    assign h_last    = (h_cnt == H_LAST);
    assign frame_end = (state == RUN) && h_last && (v_cnt == V_LAST);
    // Level/mode are captured on the edge that places the counter at (0,0).
    assign load      = en_i && ((state == IDLE) || frame_end);
    assign state_o   = (state == RUN);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a started frame always runs to its last cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en_i) state_nxt = RUN;
            RUN:  if (frame_end && !en_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q  <= '0;
            mode_q <= '0;
        end else if (load) begin
            lvl_q  <= level_i;
            mode_q <= mode_i;
        end
    end

    // Output decode of the current counter position
    always_comb begin
        de_d = (state == RUN) && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_d = (state == RUN) && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_d = (state == RUN) && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        wd_d = '0;
        if (de_d) begin
            case (mode_q)
                2'd0: wd_d = lvl_q;
                2'd1: wd_d = lvl_q + 8'(h_cnt);
                2'd2: wd_d = (h_cnt[2] ^ v_cnt[2]) ? ~lvl_q : lvl_q;
                default: wd_d = ~lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            de_o       <= 1'b0;
            wd_o       <= '0;
            frm_done_o <= 1'b0;
            frm_cnt_o  <= '0;
        end else begin
            hs_o       <= hs_d;
            vs_o       <= vs_d;
            de_o       <= de_d;
            wd_o       <= wd_d;
            frm_done_o <= frame_end;
            if (frame_end) begin
                frm_cnt_o <= frm_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frm_source.sv
// Bench for frm_source: cycle scoreboard against a behavioural raster model plus
// directed per-frame statistics checks.
module tb_frm_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] level = 8'd0;
    logic       hs_o, vs_o, de_o, frm_done_o, state_o;
    logic [7:0] wd_o, frm_cnt_o;

    frm_source dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .mode_i     (mode),
        .level_i    (level),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .de_o       (de_o),
        .wd_o       (wd_o),
        .frm_done_o (frm_done_o),
        .frm_cnt_o  (frm_cnt_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    localparam int W = 20;
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    // Behavioural raster model (24 x 12 raster, 16 x 8 active)
    bit         m_run = 1'b0;
    int         m_h = 0;
    int         m_v = 0;
    logic [7:0] m_lvl = 8'd0;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_cnt = 8'd0;
    logic       e_de, e_hs, e_vs, e_done;
    logic [7:0] e_wd;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back('0);
            m_run = 1'b0; m_h = 0; m_v = 0; m_lvl = 8'd0; m_mode = 2'd0; m_cnt = 8'd0;
        end else begin
            e_de   = m_run && m_h < 16 && m_v < 8;
            e_hs   = m_run && m_h >= 18 && m_h < 22;
            e_vs   = m_run && m_v >= 9 && m_v < 11;
            e_done = m_run && m_h == 23 && m_v == 11;
            e_wd   = 8'd0;
            if (e_de) begin
                case (m_mode)
                    2'd0: e_wd = m_lvl;
                    2'd1: e_wd = m_lvl + 8'(m_h);
                    2'd2: e_wd = (((m_h / 4) % 2) != ((m_v / 4) % 2)) ? ~m_lvl : m_lvl;
                    default: e_wd = ~m_lvl;
                endcase
            end
            if (e_done) m_cnt = m_cnt + 8'd1;
            exp_q.push_back({e_hs, e_vs, e_de, e_wd, e_done, m_cnt});
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1; m_h = 0; m_v = 0; m_lvl = level; m_mode = mode;
                end
            end else if (e_done) begin
                m_h = 0; m_v = 0;
                if (en) begin m_lvl = level; m_mode = mode; end
                else m_run = 1'b0;
            end else begin
                m_h++;
                if (m_h == 24) begin m_h = 0; m_v++; end
            end
        end
    end

    // Monitor: scoreboard pop and per-window statistics
    logic [W-1:0] sb_exp, sb_act;
    int cyc_n, de_n, hs_n, vs_n, vs_rise, done_n, nz_n, wa_n, wb_n, pix_n;
    logic [7:0] pat_a = 8'h00;
    logic [7:0] pat_b = 8'h00;
    logic [7:0] pix[16];
    logic prev_vs = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {hs_o, vs_o, de_o, wd_o, frm_done_o, frm_cnt_o};
            total++;
            assert (sb_act === sb_exp) else begin
                bad++;
                $error("FAIL scoreboard t=%0t observed=%h expected=%h", $time, sb_act, sb_exp);
            end
        end
        cyc_n++;
        if (de_o) de_n++;
        if (hs_o) hs_n++;
        if (vs_o) vs_n++;
        if (vs_o && !prev_vs) vs_rise++;
        if (frm_done_o) done_n++;
        if (hs_o || vs_o || de_o || wd_o != 8'd0 || frm_done_o) nz_n++;
        if (de_o && wd_o == pat_a) wa_n++;
        if (de_o && wd_o == pat_b) wb_n++;
        if (de_o && pix_n < 16) begin pix[pix_n] = wd_o; pix_n++; end
        prev_vs = vs_o;
    end

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear();
        cyc_n = 0; de_n = 0; hs_n = 0; vs_n = 0; vs_rise = 0;
        done_n = 0; nz_n = 0; wa_n = 0; wb_n = 0; pix_n = 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!frm_done_o && k < budget);
        chk("done_seen", int'(frm_done_o), 1);
    endtask

    initial begin
        clear();
        // 1: reset and idle
        step(3);
        chk("rst_outputs", int'({hs_o, vs_o, de_o, wd_o, frm_done_o}), 0);
        chk("rst_cnt", int'(frm_cnt_o), 0);
        rst = 1'b0;
        clear();
        step(100);
        chk("idle_nz", nz_n, 0);
        chk("idle_cnt", int'(frm_cnt_o), 0);

        // 2: mode0 solid level 0x40
        en = 1'b1; mode = 2'd0; level = 8'h40; pat_a = 8'h40; pat_b = 8'hC0;
        wait_done(400);
        clear();
        wait_done(400);
        chk("f_cycles", cyc_n, 288);
        chk("f_de", de_n, 128);
        chk("f_wd40", wa_n, 128);
        chk("f_hs", hs_n, 48);
        chk("f_vs", vs_n, 48);
        chk("f_vs_rise", vs_rise, 1);
        chk("f_done", done_n, 1);

        // 3: level change mid-frame takes effect next frame
        clear();
        step(3 * 24 + 8);
        level = 8'hC0;
        wait_done(400);
        chk("lvl_old_frame", wa_n, 128);
        chk("lvl_old_no_new", wb_n, 0);
        clear();
        wait_done(400);
        chk("lvl_new_frame", wb_n, 128);
        chk("lvl_new_de", de_n, 128);

        // 4: gradient then checker
        mode = 2'd1; level = 8'hF8;
        wait_done(400);
        clear();
        wait_done(400);
        chk("grad_pix_n", pix_n, 16);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = 8'hF8 + 8'(i);
            chk($sformatf("grad_pix%0d", i), int'(pix[i]), int'(e));
        end
        mode = 2'd2; level = 8'h10; pat_a = 8'h10; pat_b = 8'hEF;
        wait_done(400);
        clear();
        wait_done(400);
        chk("chk_lo", wa_n, 64);
        chk("chk_hi", wb_n, 64);

        // 5: en dropped at line 4 of the first frame after reset
        rst = 1'b1; mode = 2'd0; level = 8'h40;
        step(2);
        rst = 1'b0;
        step(2 + 4 * 24);
        en = 1'b0;
        clear();
        wait_done(400);
        chk("drop_done_n", done_n, 1);
        chk("drop_cnt", int'(frm_cnt_o), 1);
        clear();
        step(50);
        chk("drop_idle_nz", nz_n, 0);
        chk("drop_idle_done", done_n, 0);
        chk("drop_idle_cnt", int'(frm_cnt_o), 1);
        chk("drop_state", int'(state_o), 0);

        // 6: reset mid active line, then restart latency
        en = 1'b1;
        step(2 + 2 * 24 + 5);
        chk("mid_de", int'(de_o), 1);
        rst = 1'b1;
        step(1);
        chk("abort_outputs", int'({hs_o, vs_o, de_o, wd_o, frm_done_o}), 0);
        chk("abort_cnt", int'(frm_cnt_o), 0);
        rst = 1'b0;
        step(1);
        chk("restart_de_t1", int'(de_o), 0);
        step(1);
        chk("restart_de_t2", int'(de_o), 1);
        en = 1'b0;
        step(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
